// File: rtl/redir_pkg.sv
// Shared encodings for the stream redirector.
// Modes, FSM states and header field layout.
package redir_pkg;

  localparam logic [1:0] MODE_RR    = 2'd0;
  localparam logic [1:0] MODE_BCAST = 2'd1;
  localparam logic [1:0] MODE_HDR   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BODY = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Header: len occupies [HDR_LEN_LSB +: LEN_BITS],
  // dst sits directly above it.
  localparam int HDR_LEN_LSB = 0;

endpackage

// File: rtl/redir_out_slot.sv
// One-entry registered ap_hs output slot.
// A load may coincide with a drain; new word wins.
module redir_out_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic         free,
  output logic [W-1:0] dout,
  output logic         vld,
  input  logic         ack
);

  assign free = !vld || ack;

  // Hold word until the consumer acks it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (load) begin
      vld  <= 1'b1;
      dout <= din;
    end else if (ack) begin
      vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/data_redir_n.sv
// 1-to-N ap_hs redirector: round-robin,
// broadcast or header-routed packets.
module data_redir_n
  import redir_pkg::*;
#(
  parameter int PAYLOAD_BITS = 32,
  parameter int NUM_OUT      = 4,
  parameter int LEN_BITS     = 16
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst,
  input  logic [1:0]                      cfg_mode,
  input  logic [PAYLOAD_BITS-1:0]         Input_V_V,
  input  logic                            Input_V_V_ap_vld,
  output logic                            Input_V_V_ap_ack,
  output logic [NUM_OUT*PAYLOAD_BITS-1:0] Output_V_V,
  output logic [NUM_OUT-1:0]              Output_V_V_ap_vld,
  input  logic [NUM_OUT-1:0]              Output_V_V_ap_ack,
  output logic                            ap_idle,
  output logic [15:0]                     err_drop_cnt
);

  localparam int OUT_IDX_BITS = $clog2(NUM_OUT);
  localparam logic [OUT_IDX_BITS:0] NUM_OUT_W =
    (OUT_IDX_BITS+1)'(NUM_OUT);
  localparam logic [OUT_IDX_BITS-1:0] LAST_IDX =
    OUT_IDX_BITS'(NUM_OUT-1);

  state_t                  state_q;
  state_t                  state_d;
  logic [1:0]              mode_q;
  logic [OUT_IDX_BITS-1:0] rr_ptr_q;
  logic [OUT_IDX_BITS-1:0] dst_q;
  logic [LEN_BITS-1:0]     cnt_q;
  logic [15:0]             err_q;

  logic [NUM_OUT-1:0]      slot_free;
  logic [NUM_OUT-1:0]      slot_load;
  logic                    accept;
  logic                    is_hdr;
  logic                    hdr_start;
  logic                    hdr_bad;
  logic [LEN_BITS-1:0]     hdr_len;
  logic [OUT_IDX_BITS-1:0] hdr_dst;

  assign hdr_len = Input_V_V[HDR_LEN_LSB +: LEN_BITS];
  assign hdr_dst = Input_V_V[LEN_BITS +: OUT_IDX_BITS];
  assign hdr_bad = {1'b0, hdr_dst} >= NUM_OUT_W;
  // Reserved mode 3 behaves as header mode.
  assign is_hdr  = (mode_q == MODE_HDR) || (mode_q == 2'd3);
  assign accept  = Input_V_V_ap_ack;
  assign hdr_start = accept && (state_q == ST_IDLE)
                  && is_hdr && (hdr_len != '0);

  assign ap_idle = (state_q == ST_IDLE)
                && !(|Output_V_V_ap_vld);
  assign err_drop_cnt = err_q;

  // State register.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: packets run header -> body/drop -> idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hdr_start)
          state_d = hdr_bad ? ST_DROP : ST_BODY;
      end
      ST_BODY, ST_DROP: begin
        if (accept && cnt_q == LEN_BITS'(1))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: input ack and per-slot load strobes.
  always_comb begin
    logic tgt_free;
    tgt_free  = 1'b1;
    slot_load = '0;
    unique case (state_q)
      ST_IDLE: begin
        unique case (1'b1)
          (mode_q == MODE_RR):    tgt_free = slot_free[rr_ptr_q];
          (mode_q == MODE_BCAST): tgt_free = &slot_free;
          default:                tgt_free = 1'b1;
        endcase
      end
      ST_BODY: tgt_free = slot_free[dst_q];
      default: tgt_free = 1'b1;
    endcase
    Input_V_V_ap_ack = !ap_rst && Input_V_V_ap_vld && tgt_free;
    if (Input_V_V_ap_ack) begin
      unique case (state_q)
        ST_IDLE: begin
          if (mode_q == MODE_RR)    slot_load[rr_ptr_q] = 1'b1;
          if (mode_q == MODE_BCAST) slot_load = '1;
        end
        ST_BODY: slot_load[dst_q] = 1'b1;
        default: slot_load = '0;
      endcase
    end
  end

  // Mode latch, rr pointer, packet counter, drop counter.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      mode_q   <= MODE_RR;
      rr_ptr_q <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      err_q    <= '0;
    end else begin
      if (state_q == ST_IDLE) mode_q <= cfg_mode;
      if (accept && state_q == ST_IDLE && mode_q == MODE_RR)
        rr_ptr_q <= (rr_ptr_q == LAST_IDX) ? '0
                  : rr_ptr_q + OUT_IDX_BITS'(1);
      if (hdr_start) begin
        cnt_q <= hdr_len;
        dst_q <= hdr_dst;
        if (hdr_bad && err_q != 16'hFFFF)
          err_q <= err_q + 16'd1;
      end else if (accept && state_q != ST_IDLE) begin
        cnt_q <= cnt_q - LEN_BITS'(1);
      end
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    redir_out_slot #(.W(PAYLOAD_BITS)) u_slot (
      .clk  (ap_clk),
      .rst  (ap_rst),
      .load (slot_load[k]),
      .din  (Input_V_V),
      .free (slot_free[k]),
      .dout (Output_V_V[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .vld  (Output_V_V_ap_vld[k]),
      .ack  (Output_V_V_ap_ack[k])
    );
  end

endmodule

// File: tb/tb_data_redir_n.sv
// Bench for data_redir_n: 4-channel and
// 3-channel instances, queue scoreboard.
module tb_data_redir_n;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]      cfg;
  logic [W-1:0]    din;
  logic            vin;
  logic            ain;
  logic [N*W-1:0]  dout;
  logic [N-1:0]    ovld;
  logic [N-1:0]    oack;
  logic            idle;
  logic [15:0]     errc;

  logic [1:0]      cfg3;
  logic [W-1:0]    din3;
  logic            vin3;
  logic            ain3;
  logic [N3*W-1:0] dout3;
  logic [N3-1:0]   ovld3;
  logic [N3-1:0]   oack3;
  logic            idle3;
  logic [15:0]     errc3;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] exp_q  [N][$];
  logic [W-1:0] exp3_q [N3][$];

  data_redir_n #(.PAYLOAD_BITS(W), .NUM_OUT(N), .LEN_BITS(16)) u_dut (
    .ap_clk(clk), .ap_rst(rst), .cfg_mode(cfg),
    .Input_V_V(din), .Input_V_V_ap_vld(vin), .Input_V_V_ap_ack(ain),
    .Output_V_V(dout), .Output_V_V_ap_vld(ovld),
    .Output_V_V_ap_ack(oack), .ap_idle(idle), .err_drop_cnt(errc)
  );

  data_redir_n #(.PAYLOAD_BITS(W), .NUM_OUT(N3), .LEN_BITS(16)) u_dut3 (
    .ap_clk(clk), .ap_rst(rst), .cfg_mode(cfg3),
    .Input_V_V(din3), .Input_V_V_ap_vld(vin3), .Input_V_V_ap_ack(ain3),
    .Output_V_V(dout3), .Output_V_V_ap_vld(ovld3),
    .Output_V_V_ap_ack(oack3), .ap_idle(idle3), .err_drop_cnt(errc3)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: every output transfer pops its channel queue.
  always begin
    logic [W-1:0] e;
    @(negedge clk);
    #2;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (ovld[k] && oack[k]) begin
          if (exp_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected ch%0d actual=%h required=none",
                     k, dout[k*W +: W]);
          end else begin
            e = exp_q[k].pop_front();
            chk($sformatf("ch%0d_data", k), dout[k*W +: W], e);
          end
        end
      end
      for (int k = 0; k < N3; k++) begin
        if (ovld3[k] && oack3[k]) begin
          if (exp3_q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected3 ch%0d actual=%h required=none",
                     k, dout3[k*W +: W]);
          end else begin
            e = exp3_q[k].pop_front();
            chk($sformatf("d3_ch%0d_data", k), dout3[k*W +: W], e);
          end
        end
      end
    end
  end

  // ch >= 0: one channel, -1: none (header/drop), -2: all.
  task automatic put(input logic [W-1:0] w, input int ch,
                     input int exp_st, input string nm);
    bit acc;
    int st;
    acc = 1'b0;
    st  = 0;
    din = w;
    vin = 1'b1;
    while (!acc && st <= 50) begin
      #1 acc = ain;
      @(posedge clk);
      @(negedge clk);
      if (!acc) st++;
    end
    vin = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=noack required=ack", nm);
    end else begin
      if (ch >= 0) exp_q[ch].push_back(w);
      if (ch == -2)
        for (int k = 0; k < N; k++) exp_q[k].push_back(w);
      chk(nm, st, exp_st);
    end
  endtask

  task automatic put3(input logic [W-1:0] w, input int ch,
                      input string nm);
    bit acc;
    int st;
    acc  = 1'b0;
    st   = 0;
    din3 = w;
    vin3 = 1'b1;
    while (!acc && st <= 50) begin
      #1 acc = ain3;
      @(posedge clk);
      @(negedge clk);
      if (!acc) st++;
    end
    vin3 = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=noack required=ack", nm);
    end else begin
      if (ch >= 0) exp3_q[ch].push_back(w);
      chk(nm, st, 0);
    end
  endtask

  task automatic try_word(input logic [W-1:0] w, output bit acc);
    din = w;
    vin = 1'b1;
    #1 acc = ain;
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
  endtask

  task automatic flush(input string nm);
    vin   = 1'b0;
    vin3  = 1'b0;
    oack  = '1;
    oack3 = '1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_left%0d", nm, k), exp_q[k].size(), 0);
    for (int k = 0; k < N3; k++)
      chk($sformatf("%s_left3_%0d", nm, k), exp3_q[k].size(), 0);
    chk({nm, "_idle"}, idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    cfg   = 2'd0;
    din   = '0;
    vin   = 1'b1;
    oack  = '1;
    cfg3  = 2'd2;
    din3  = '0;
    vin3  = 1'b1;
    oack3 = '1;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ack", ain, 0);
    chk("rst_ack3", ain3, 0);
    vin  = 1'b0;
    vin3 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_vld", ovld, 0);
    chk("rst_dout", dout[31:0] | dout[63:32] | dout[95:64]
                    | dout[127:96], 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", errc, 0);
    chk("rst_err3", errc3, 0);
    @(negedge clk);

    // Round-robin, all acks high.
    for (int i = 1; i <= 8; i++) begin
      put(W'(i), (i - 1) % 4, 0, "rr_stall");
      if (i == 1) begin
        chk("rr_lat_vld", ovld[0], 1);
        chk("rr_lat_data", dout[31:0], 1);
      end
    end
    flush("rr");

    // Round-robin with ch1 backpressure; rr_ptr restarts at 0.
    oack[1] = 1'b0;
    put(32'd11, 0, 0, "bp_stall");
    put(32'd12, 1, 0, "bp_stall");
    put(32'd13, 2, 0, "bp_stall");
    put(32'd14, 3, 0, "bp_stall");
    put(32'd15, 0, 0, "bp_stall");
    for (int i = 0; i < 5; i++) begin
      try_word(32'd16, acc);
      chk("bp_ack_low", acc, 0);
    end
    oack[1] = 1'b1;
    put(32'd16, 1, 0, "bp_resume");
    put(32'd17, 2, 0, "bp_noskip");
    put(32'd18, 3, 0, "bp_noskip");
    flush("bp");

    // Broadcast with ch2 stalled.
    cfg = 2'd1;
    @(negedge clk);
    oack[2] = 1'b0;
    put(32'hA5A5_0001, -2, 0, "bc_stall");
    for (int k = 0; k < N; k++) begin
      chk($sformatf("bc_vld%0d", k), ovld[k], 1);
      chk($sformatf("bc_data%0d", k), dout[k*W +: W], 32'hA5A5_0001);
    end
    for (int i = 0; i < 2; i++) begin
      try_word(32'hA5A5_0002, acc);
      chk("bc_ack_low", acc, 0);
      chk("bc_hold2", dout[2*W +: W], 32'hA5A5_0001);
    end
    oack[2] = 1'b1;
    put(32'hA5A5_0002, -2, 0, "bc_resume");
    flush("bc");

    // Header-routed packet to ch2, then a len=0 header.
    cfg = 2'd2;
    @(negedge clk);
    put(32'h0002_0003, -1, 0, "hdr_hdr");
    chk("hdr_busy", idle, 0);
    put(32'hD000_0000, 2, 0, "hdr_body");
    put(32'hD000_0001, 2, 0, "hdr_body");
    put(32'hD000_0002, 2, 0, "hdr_body");
    flush("hdr");
    put(32'h0001_0000, -1, 0, "hdr_len0");
    chk("len0_idle", idle, 1);
    put(32'h0001_0001, -1, 0, "hdr_hdr2");
    put(32'h0000_BEEF, 1, 0, "hdr_body2");
    flush("len0");

    // Bad destination drop on the 3-channel instance.
    put3(32'h0003_0002, -1, "drop_hdr");
    chk("drop_err", errc3, 1);
    chk("drop_busy", idle3, 0);
    put3(32'h1111_1111, -1, "drop_w");
    put3(32'h2222_2222, -1, "drop_w");
    chk("drop_done_idle", idle3, 1);
    put3(32'h0001_0001, -1, "drop_next_hdr");
    put3(32'h0000_0077, 1, "drop_next_body");
    flush("drop");
    chk("drop_err_final", errc3, 1);

    // Reset in the middle of a 3-word packet.
    put(32'h0002_0003, -1, 0, "mid_hdr");
    put(32'hC0DE_0000, 2, 0, "mid_body");
    @(negedge clk);
    rst = 1'b1;
    vin = 1'b1;
    din = 32'hC0DE_0001;
    #1;
    chk("mid_rst_ack", ain, 0);
    @(posedge clk);
    @(negedge clk);
    vin = 1'b0;
    rst = 1'b0;
    chk("mid_vld", ovld, 0);
    chk("mid_idle", idle, 1);
    chk("mid_err", errc, 0);
    @(negedge clk);
    put(32'h0001_0001, -1, 0, "mid_new_hdr");
    put(32'h0000_E001, 1, 0, "mid_new_body");
    flush("mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
